// File: rtl/pc_fetch_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pc_fetch_sequencer
// Brief    : MIPS program counter / instruction fetch stage with next-PC logic,
//            retired-instruction counter and sticky fetch-timeout error.
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        stall,
    input  logic        Jump,
    input  logic        Jal,
    input  logic        BranchEQ,
    input  logic        BranchNE,
    input  logic        zero,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] retired,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    localparam logic [15:0] C_WAIT_LIMIT = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] retired_q, retired_d;
    logic [15:0] wait_q, wait_d;
    logic        imem_req_q, imem_req_d;
    logic        instr_valid_q, instr_valid_d;
    logic        fetch_err_q, fetch_err_d;

    logic [31:0] pc4;
    logic [31:0] jtarget;
    logic [31:0] btarget;
    logic [31:0] imm_ext;
    logic        taken;
    logic        jump_sel;
    logic [31:0] next_pc;

    // Jal only ever qualifies a jump the decoder already flagged; alone it selects pc4.
    always_comb begin
        pc4      = pc_q + 32'd4;
        jtarget  = {pc4[31:28], instr_q[25:0], 2'b00};
        imm_ext  = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
        btarget  = pc4 + imm_ext;
        taken    = (BranchEQ & zero) | (BranchNE & ~zero);
        jump_sel = Jump | (Jump & Jal);
        if (jump_sel) begin
            next_pc = jtarget;
        end else if (taken) begin
            next_pc = btarget;
        end else begin
            next_pc = pc4;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        retired_d = retired_q;
        wait_d    = wait_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                // A ready arriving on the limit cycle still wins over the timeout.
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    wait_d  = 16'd0;
                    state_d = ST_EXEC;
                end else if (wait_q == C_WAIT_LIMIT) begin
                    wait_d  = 16'd0;
                    state_d = ST_ERROR;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            ST_EXEC: begin
                if (!stall) begin
                    retired_d = retired_q + 32'd1;
                    pc_d      = next_pc;
                    state_d   = ST_FETCH;
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        imem_req_d    = (state_d == ST_FETCH);
        instr_valid_d = (state_d == ST_EXEC);
        fetch_err_d   = (state_d == ST_ERROR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= 32'd0;
            retired_q     <= 32'd0;
            wait_q        <= 16'd0;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            retired_q     <= retired_d;
            wait_q        <= wait_d;
            imem_req_q    <= imem_req_d;
            instr_valid_q <= instr_valid_d;
            fetch_err_q   <= fetch_err_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc4;
    assign retired     = retired_q;
    assign fetch_err   = fetch_err_q;

endmodule
`default_nettype wire
